// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake bundle for pipe_stage_skid
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_wr_reg;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_rd_data;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [REG_W-1:0]  out_wr_reg;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_rd_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_wr_reg, in_pc, in_alu_res, in_rd_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_wr_reg, out_pc, out_alu_res, out_rd_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_wr_reg, in_pc, in_alu_res, in_rd_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_wr_reg, out_pc, out_alu_res, out_rd_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with one-entry skid, flush and stall/flush counters
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int PAY_W = REG_W + 3 * DATA_W + CTRL_W;

  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  main_pay;
  logic [PAY_W-1:0]  skid_pay;
  logic              main_valid;
  logic              skid_valid;
  logic              in_ready_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic accept;
  logic pop;
  logic main_valid_d;
  logic skid_valid_d;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  assign in_pay = {bus.in_wr_reg, bus.in_pc, bus.in_alu_res, bus.in_rd_data, bus.in_ctrl};
  assign accept = bus.in_valid & in_ready_q;
  assign pop    = main_valid & bus.out_ready;

  always_comb begin
    main_valid_d        = main_valid;
    skid_valid_d        = skid_valid;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid) begin
      // in_ready is low whenever skid is full, so no accept can collide here
      load_main_from_skid = 1'b1;
      main_valid_d        = 1'b1;
      skid_valid_d        = 1'b0;
    end else if (accept && (!main_valid || pop)) begin
      load_main_from_in = 1'b1;
      main_valid_d      = 1'b1;
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
      main_pay   <= '0;
      skid_pay   <= '0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready_q <= !skid_valid_d;
      if (load_main_from_skid) begin
        main_pay <= skid_pay;
      end else if (load_main_from_in) begin
        main_pay <= in_pay;
      end
      if (load_skid) begin
        skid_pay <= in_pay;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !bus.out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      // only flushes that actually killed something are interesting
      if (flush && (main_valid || skid_valid) && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign {bus.out_wr_reg, bus.out_pc, bus.out_alu_res, bus.out_rd_data, ctrl_q} = main_pay;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = ctrl_q & {CTRL_W{main_valid}};
  assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and random scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [REG_W-1:0]  wr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  ent_t             q[$];
  ent_t             shown;
  ent_t             cur;
  logic             exp_rdy;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown     = '0;
    exp_rdy   = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic check_all(input string tag);
    logic          v;
    logic [CTRL_W-1:0] c;
    v = (q.size() > 0);
    c = v ? shown.ctrl : '0;
    chk({tag, ".out_valid"},   64'(bus.out_valid),   64'(v));
    chk({tag, ".in_ready"},    64'(bus.in_ready),    64'(exp_rdy));
    chk({tag, ".stall_cnt"},   64'(stall_cnt),       64'(exp_stall));
    chk({tag, ".flush_cnt"},   64'(flush_cnt),       64'(exp_flush));
    chk({tag, ".out_pc"},      64'(bus.out_pc),      64'(shown.pc));
    chk({tag, ".out_alu_res"}, 64'(bus.out_alu_res), 64'(shown.alu));
    chk({tag, ".out_rd_data"}, 64'(bus.out_rd_data), 64'(shown.rd));
    chk({tag, ".out_wr_reg"},  64'(bus.out_wr_reg),  64'(shown.wr));
    chk({tag, ".out_ctrl"},    64'(bus.out_ctrl),    64'(c));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] ctrl,
                       input logic ordy, input logic fl);
    cur.pc   = pc;
    cur.alu  = pc ^ 32'h5a5a_0000;
    cur.rd   = ~pc;
    cur.wr   = pc[6:2];
    cur.ctrl = ctrl;
    bus.in_valid   = v;
    bus.in_pc      = cur.pc;
    bus.in_alu_res = cur.alu;
    bus.in_rd_data = cur.rd;
    bus.in_wr_reg  = cur.wr;
    bus.in_ctrl    = cur.ctrl;
    bus.out_ready  = ordy;
    flush          = fl;
  endtask

  task automatic step(input string tag);
    logic acc;
    logic pp;
    acc = bus.in_valid && exp_rdy;
    pp  = (q.size() > 0) && bus.out_ready;
    if (q.size() > 0 && !bus.out_ready && exp_stall != CNT_MAX) exp_stall++;
    if (flush && q.size() > 0 && exp_flush != CNT_MAX) exp_flush++;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      exp_rdy = 1'b1;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur);
      exp_rdy = (q.size() < 2);
    end
    if (q.size() > 0) shown = q[0];
    check_all(tag);
  endtask

  initial begin
    model_reset();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      check_all("reset");
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step("release");

    // streaming
    drive(1'b1, 32'h100, 4'h1, 1'b1, 1'b0); step("stream0");
    drive(1'b1, 32'h104, 4'h3, 1'b1, 1'b0); step("stream1");
    drive(1'b1, 32'h108, 4'h7, 1'b1, 1'b0); step("stream2");
    drive(1'b0, 32'h0,   4'h0, 1'b1, 1'b0); step("stream3");
    step("stream4");

    // backpressure into the skid slot
    drive(1'b1, 32'h200, 4'h9, 1'b1, 1'b0); step("bp_a");
    drive(1'b1, 32'h204, 4'ha, 1'b0, 1'b0); step("bp_b");
    drive(1'b1, 32'h208, 4'hb, 1'b0, 1'b0); step("bp_hold0");
    step("bp_hold1");
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);   step("bp_drain0");
    step("bp_drain1");
    step("bp_drain2");

    // flush with both slots full and an entry on offer
    drive(1'b1, 32'h2f0, 4'h5, 1'b0, 1'b0); step("fl_fill0");
    drive(1'b1, 32'h2f4, 4'h6, 1'b0, 1'b0); step("fl_fill1");
    drive(1'b1, 32'h300, 4'hf, 1'b0, 1'b1); step("fl_kill");
    drive(1'b1, 32'h304, 4'hc, 1'b0, 1'b1); step("fl_empty");
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);   step("fl_after");

    // bubble gating of control bits
    drive(1'b1, 32'hdead_beec, 4'hf, 1'b1, 1'b0); step("bub_push");
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);         step("bub_pop");
    step("bub_idle");

    // counter saturation, then async reset mid-stall
    drive(1'b1, 32'h400, 4'h2, 1'b0, 1'b0); step("sat_push");
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("sat_stall");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    rst = 1'b1;
    step("rerelease");

    // random traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), 4'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
      step("random");
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step("final0");
    step("final1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
